// File: rtl/swarm.sv
// ============================================================================
// swarm : shared task, slot and server-state types for the tile task path
// Rev 1.0
// ============================================================================
`default_nettype none

package swarm;

    typedef logic [3:0] task_type_t;
    typedef logic [5:0] cq_slice_slot_t;
    typedef logic [2:0] child_id_t;

    typedef struct packed {
        task_type_t  ttype;
        logic [15:0] ts;
        logic [15:0] locale;
    } task_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DISPATCHED = 2'd1,
        RUNNING    = 2'd2
    } core_srv_state_t;

endpackage

`default_nettype wire

// File: rtl/task_slot_fifo.sv
// ============================================================================
// task_slot_fifo : ready-task FIFO of {task, slot, killed} with a slot-matched
// kill port.  Rev 1.0
// ============================================================================
`default_nettype none

module task_slot_fifo
    import swarm::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           push,
    input  wire task_t          push_task,
    input  wire cq_slice_slot_t push_slot,
    input  wire logic           pop,
    input  wire logic           kill_valid,
    input  wire cq_slice_slot_t kill_slot,
    output task_t               head_task,
    output cq_slice_slot_t      head_slot,
    output logic                head_killed,
    output logic                empty,
    output logic                full
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    task_t            r_task [DEPTH];
    cq_slice_slot_t   r_slot [DEPTH];
    logic [DEPTH-1:0] r_killed;

    logic [c_AW:0]    w_count;
    logic [DEPTH-1:0] w_kill_hit;
    logic             w_push;
    logic             w_pop;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push  = push & ~full;
    assign w_pop   = pop & ~empty;

    // An entry is live when its distance from the read pointer is below count
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [c_AW-1:0] w_off;
        assign w_off = c_AW'(gi) - r_rd_ptr[c_AW-1:0];
        assign w_kill_hit[gi] = kill_valid && ({1'b0, w_off} < w_count) &&
                                (r_slot[gi] == kill_slot);
    end

    assign head_task   = r_task[r_rd_ptr[c_AW-1:0]];
    assign head_slot   = r_slot[r_rd_ptr[c_AW-1:0]];
    assign head_killed = r_killed[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_killed <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr[c_AW-1:0] == c_AW'(i)))
                    r_killed[i] <= kill_valid && (kill_slot == push_slot);
                else if (w_kill_hit[i])
                    r_killed[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_task[r_wr_ptr[c_AW-1:0]] <= push_task;
            r_slot[r_wr_ptr[c_AW-1:0]] <= push_slot;
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_task_server.sv
// ============================================================================
// core_task_server : per-core dequeue/start/finish responder and abort router.
// Optional statistics counters: CORE_TASK_SERVER_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module core_task_server
    import swarm::*;
#(
    parameter int CORE_ID = 0,
    parameter int TILE_ID = 0,
    parameter int DEPTH   = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           tq_valid,
    output logic                tq_ready,
    input  wire task_t          tq_task,
    input  wire cq_slice_slot_t tq_slot,
    input  wire logic           task_arvalid,
    input  wire task_type_t     task_araddr,
    output logic                task_rvalid,
    output task_t               task_rdata,
    output cq_slice_slot_t      task_rslot,
    input  wire logic           start_task_valid,
    output logic                start_task_ready,
    input  wire cq_slice_slot_t start_task_slot,
    input  wire logic           finish_task_valid,
    output logic                finish_task_ready,
    input  wire cq_slice_slot_t finish_task_slot,
    input  wire child_id_t      finish_task_num_children,
    input  wire logic           finish_task_undo_log_write,
    output logic                cq_start_valid,
    input  wire logic           cq_start_ready,
    output cq_slice_slot_t      cq_start_slot,
    output logic                cq_finish_valid,
    input  wire logic           cq_finish_ready,
    output cq_slice_slot_t      cq_finish_slot,
    output child_id_t           cq_finish_num_children,
    output logic                cq_finish_undo_log_write,
    input  wire logic           abort_req_valid,
    input  wire cq_slice_slot_t abort_req_slot,
    output logic                abort_running_task,
    output cq_slice_slot_t      abort_running_slot,
    output logic                slot_err,
    output logic [31:0]         stat_dispatches,
    output logic [31:0]         stat_aborts
);

    core_srv_state_t r_state, w_state_nxt;
    cq_slice_slot_t  r_run_slot, w_run_slot_nxt;
    logic            r_abort, r_slot_err;
    cq_slice_slot_t  r_abort_slot;

    task_t           w_head_task;
    cq_slice_slot_t  w_head_slot;
    logic            w_head_killed, w_empty, w_full;
    logic            w_dispatch, w_discard, w_start_hs, w_finish_hs, w_abort_hit;

    task_slot_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (tq_valid),
        .push_task   (tq_task),
        .push_slot   (tq_slot),
        .pop         (w_dispatch | w_discard),
        .kill_valid  (abort_req_valid),
        .kill_slot   (abort_req_slot),
        .head_task   (w_head_task),
        .head_slot   (w_head_slot),
        .head_killed (w_head_killed),
        .empty       (w_empty),
        .full        (w_full)
    );

    assign tq_ready    = ~w_full;
    assign w_discard   = ~w_empty & w_head_killed;
    assign w_dispatch  = task_arvalid & (r_state == IDLE) & ~w_empty & ~w_head_killed &
                         (w_head_task.ttype == task_araddr);
    assign task_rvalid = w_dispatch;
    assign task_rdata  = w_head_task;
    assign task_rslot  = w_head_slot;

    assign cq_start_valid   = start_task_valid & (r_state == DISPATCHED);
    assign start_task_ready = cq_start_ready & (r_state == DISPATCHED);
    assign cq_start_slot    = start_task_slot;
    assign w_start_hs       = cq_start_valid & cq_start_ready;

    assign cq_finish_valid          = finish_task_valid & (r_state == RUNNING);
    assign finish_task_ready        = cq_finish_ready & (r_state == RUNNING);
    assign cq_finish_slot           = finish_task_slot;
    assign cq_finish_num_children   = finish_task_num_children;
    assign cq_finish_undo_log_write = finish_task_undo_log_write;
    assign w_finish_hs              = cq_finish_valid & cq_finish_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (w_dispatch)  w_state_nxt = DISPATCHED;
            DISPATCHED: if (w_start_hs)  w_state_nxt = RUNNING;
            RUNNING:    if (w_finish_hs) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Comparing against next-cycle state/slot covers abort-with-finish (no
    // pulse) and abort-with-dispatch (pulse on the freshly dispatched slot).
    assign w_run_slot_nxt = w_dispatch ? w_head_slot : r_run_slot;
    assign w_abort_hit    = abort_req_valid & (w_state_nxt != IDLE) &
                            (abort_req_slot == w_run_slot_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_run_slot   <= '0;
            r_abort      <= 1'b0;
            r_abort_slot <= '0;
            r_slot_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_run_slot   <= w_run_slot_nxt;
            r_abort      <= w_abort_hit;
            r_abort_slot <= w_abort_hit ? w_run_slot_nxt : '0;
            if ((w_start_hs && (start_task_slot != r_run_slot)) ||
                (w_finish_hs && (finish_task_slot != r_run_slot)))
                r_slot_err <= 1'b1;
        end
    end

    assign abort_running_task = r_abort;
    assign abort_running_slot = r_abort_slot;
    assign slot_err           = r_slot_err;

`ifdef CORE_TASK_SERVER_STATS_EN
    logic [31:0] r_stat_disp, r_stat_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_disp  <= '0;
            r_stat_abort <= '0;
        end else begin
            if (w_dispatch && (r_stat_disp != 32'hFFFF_FFFF))
                r_stat_disp <= r_stat_disp + 32'd1;
            if (w_abort_hit && (r_stat_abort != 32'hFFFF_FFFF))
                r_stat_abort <= r_stat_abort + 32'd1;
        end
    end

    assign stat_dispatches = r_stat_disp;
    assign stat_aborts     = r_stat_abort;
`else
    assign stat_dispatches = '0;
    assign stat_aborts     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_task_server.sv
// ============================================================================
// tb_core_task_server : directed self-checking bench for core_task_server.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_core_task_server;
    import swarm::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tq_valid = 1'b0;
    logic           tq_ready;
    task_t          tq_task = '0;
    cq_slice_slot_t tq_slot = '0;
    logic           task_arvalid = 1'b0;
    task_type_t     task_araddr = '0;
    logic           task_rvalid;
    task_t          task_rdata;
    cq_slice_slot_t task_rslot;
    logic           start_task_valid = 1'b0;
    logic           start_task_ready;
    cq_slice_slot_t start_task_slot = '0;
    logic           finish_task_valid = 1'b0;
    logic           finish_task_ready;
    cq_slice_slot_t finish_task_slot = '0;
    child_id_t      finish_task_num_children = '0;
    logic           finish_task_undo_log_write = 1'b0;
    logic           cq_start_valid;
    logic           cq_start_ready = 1'b0;
    cq_slice_slot_t cq_start_slot;
    logic           cq_finish_valid;
    logic           cq_finish_ready = 1'b0;
    cq_slice_slot_t cq_finish_slot;
    child_id_t      cq_finish_num_children;
    logic           cq_finish_undo_log_write;
    logic           abort_req_valid = 1'b0;
    cq_slice_slot_t abort_req_slot = '0;
    logic           abort_running_task;
    cq_slice_slot_t abort_running_slot;
    logic           slot_err;
    logic [31:0]    stat_dispatches;
    logic [31:0]    stat_aborts;

    int n_checks = 0;
    int n_pass   = 0;
    int n_disp   = 0;
    int n_abort  = 0;

    always #5 clk = ~clk;

    core_task_server #(.CORE_ID(0), .TILE_ID(0), .DEPTH(4)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .tq_valid                   (tq_valid),
        .tq_ready                   (tq_ready),
        .tq_task                    (tq_task),
        .tq_slot                    (tq_slot),
        .task_arvalid               (task_arvalid),
        .task_araddr                (task_araddr),
        .task_rvalid                (task_rvalid),
        .task_rdata                 (task_rdata),
        .task_rslot                 (task_rslot),
        .start_task_valid           (start_task_valid),
        .start_task_ready           (start_task_ready),
        .start_task_slot            (start_task_slot),
        .finish_task_valid          (finish_task_valid),
        .finish_task_ready          (finish_task_ready),
        .finish_task_slot           (finish_task_slot),
        .finish_task_num_children   (finish_task_num_children),
        .finish_task_undo_log_write (finish_task_undo_log_write),
        .cq_start_valid             (cq_start_valid),
        .cq_start_ready             (cq_start_ready),
        .cq_start_slot              (cq_start_slot),
        .cq_finish_valid            (cq_finish_valid),
        .cq_finish_ready            (cq_finish_ready),
        .cq_finish_slot             (cq_finish_slot),
        .cq_finish_num_children     (cq_finish_num_children),
        .cq_finish_undo_log_write   (cq_finish_undo_log_write),
        .abort_req_valid            (abort_req_valid),
        .abort_req_slot             (abort_req_slot),
        .abort_running_task         (abort_running_task),
        .abort_running_slot         (abort_running_slot),
        .slot_err                   (slot_err),
        .stat_dispatches            (stat_dispatches),
        .stat_aborts                (stat_aborts)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] exp_stat(input int n);
`ifdef CORE_TASK_SERVER_STATS_EN
        return 32'(n);
`else
        return (n > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // All helpers start and end just after a falling edge.
    task automatic push(input task_type_t tt, input cq_slice_slot_t s);
        tq_valid = 1'b1;
        tq_task  = '{ttype: tt, ts: 16'(s) + 16'h100, locale: 16'hA000 | 16'(s)};
        tq_slot  = s;
        @(negedge clk);
        tq_valid = 1'b0;
    endtask

    task automatic do_dispatch(input task_type_t tt, input cq_slice_slot_t s);
        task_arvalid = 1'b1;
        task_araddr  = tt;
        #1;
        chk("disp_rvalid", 32'(task_rvalid), 32'd1);
        chk("disp_rslot", 32'(task_rslot), 32'(s));
        chk("disp_rtype", 32'(task_rdata.ttype), 32'(tt));
        chk("disp_rlocale", 32'(task_rdata.locale), 32'(16'hA000 | 16'(s)));
        n_disp++;
        @(negedge clk);
        task_arvalid = 1'b0;
    endtask

    task automatic do_start(input cq_slice_slot_t s);
        start_task_valid = 1'b1;
        start_task_slot  = s;
        cq_start_ready   = 1'b1;
        #1;
        chk("start_cqvalid", 32'(cq_start_valid), 32'd1);
        chk("start_ready", 32'(start_task_ready), 32'd1);
        chk("start_cqslot", 32'(cq_start_slot), 32'(s));
        @(negedge clk);
        start_task_valid = 1'b0;
        cq_start_ready   = 1'b0;
    endtask

    task automatic do_finish(input cq_slice_slot_t s, input child_id_t nc, input logic u);
        finish_task_valid          = 1'b1;
        finish_task_slot           = s;
        finish_task_num_children   = nc;
        finish_task_undo_log_write = u;
        cq_finish_ready            = 1'b1;
        #1;
        chk("fin_cqvalid", 32'(cq_finish_valid), 32'd1);
        chk("fin_ready", 32'(finish_task_ready), 32'd1);
        chk("fin_cqslot", 32'(cq_finish_slot), 32'(s));
        chk("fin_nchild", 32'(cq_finish_num_children), 32'(nc));
        chk("fin_undo", 32'(cq_finish_undo_log_write), 32'(u));
        @(negedge clk);
        finish_task_valid = 1'b0;
        cq_finish_ready   = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tq_ready", 32'(tq_ready), 32'd1);
        chk("rst_rvalid", 32'(task_rvalid), 32'd0);
        chk("rst_abort", 32'(abort_running_task), 32'd0);
        chk("rst_abort_slot", 32'(abort_running_slot), 32'd0);
        chk("rst_cq_start_valid", 32'(cq_start_valid), 32'd0);
        chk("rst_cq_finish_valid", 32'(cq_finish_valid), 32'd0);
        chk("rst_slot_err", 32'(slot_err), 32'd0);
        chk("rst_stat_disp", stat_dispatches, 32'd0);
        chk("rst_stat_abort", stat_aborts, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Three tasks dispatched in order, start gated outside DISPATCHED
        push(4'd0, 6'd5);
        push(4'd0, 6'd6);
        push(4'd0, 6'd7);
        start_task_valid = 1'b1;
        cq_start_ready   = 1'b1;
        #1;
        chk("idle_start_blocked", 32'(cq_start_valid), 32'd0);
        chk("idle_start_ready", 32'(start_task_ready), 32'd0);
        start_task_valid = 1'b0;
        cq_start_ready   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            do_dispatch(4'd0, 6'(5 + i));
            task_arvalid = 1'b1;
            #1;
            chk("dispatched_no_deq", 32'(task_rvalid), 32'd0);
            task_arvalid = 1'b0;
            do_start(6'(5 + i));
            do_finish(6'(5 + i), 3'(i + 1), i[0]);
        end

        // Full FIFO, wrong-type head blocks, dropped push when full
        for (int i = 0; i < 4; i++) push(4'd2, 6'(10 + i));
        chk("full_tq_ready", 32'(tq_ready), 32'd0);
        tq_valid = 1'b1;
        tq_slot  = 6'd14;
        tq_task  = '{ttype: 4'd2, ts: 16'h0, locale: 16'h0};
        task_arvalid = 1'b1;
        task_araddr  = 4'd1;
        #1;
        chk("wrong_type_blocks", 32'(task_rvalid), 32'd0);
        @(negedge clk);
        tq_valid     = 1'b0;
        task_arvalid = 1'b0;
        do_dispatch(4'd2, 6'd10);
        #1;
        chk("after_pop_tq_ready", 32'(tq_ready), 32'd1);
        do_start(6'd10);
        do_finish(6'd10, 3'd0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            do_dispatch(4'd2, 6'(10 + i));
            do_start(6'(10 + i));
            do_finish(6'(10 + i), 3'd0, 1'b0);
        end
        task_arvalid = 1'b1;
        task_araddr  = 4'd2;
        #1;
        chk("drained_empty", 32'(task_rvalid), 32'd0);
        task_arvalid = 1'b0;
        @(negedge clk);

        // Abort of the running task
        push(4'd0, 6'd5);
        do_dispatch(4'd0, 6'd5);
        do_start(6'd5);
        abort_req_valid = 1'b1;
        abort_req_slot  = 6'd5;
        #1;
        chk("abort_not_yet", 32'(abort_running_task), 32'd0);
        @(negedge clk);
        abort_req_valid = 1'b0;
        n_abort++;
        chk("abort_pulse", 32'(abort_running_task), 32'd1);
        chk("abort_pulse_slot", 32'(abort_running_slot), 32'd5);
        @(negedge clk);
        chk("abort_one_cycle", 32'(abort_running_task), 32'd0);
        do_finish(6'd5, 3'd0, 1'b0);

        // Abort of a queued entry: skipped, no pulse
        push(4'd0, 6'd6);
        push(4'd0, 6'd7);
        abort_req_valid = 1'b1;
        abort_req_slot  = 6'd6;
        @(negedge clk);
        abort_req_valid = 1'b0;
        task_arvalid    = 1'b1;
        task_araddr     = 4'd0;
        #1;
        chk("kill_no_pulse", 32'(abort_running_task), 32'd0);
        chk("killed_head_held", 32'(task_rvalid), 32'd0);
        @(negedge clk);
        do_dispatch(4'd0, 6'd7);
        do_start(6'd7);
        do_finish(6'd7, 3'd0, 1'b0);

        // Abort coincident with finish handshake
        push(4'd0, 6'd5);
        do_dispatch(4'd0, 6'd5);
        do_start(6'd5);
        finish_task_valid = 1'b1;
        finish_task_slot  = 6'd5;
        cq_finish_ready   = 1'b1;
        abort_req_valid   = 1'b1;
        abort_req_slot    = 6'd5;
        #1;
        chk("abfin_cq_valid", 32'(cq_finish_valid), 32'd1);
        @(negedge clk);
        abort_req_valid = 1'b0;
        #1;
        chk("abfin_once", 32'(cq_finish_valid), 32'd0);
        chk("abfin_no_pulse", 32'(abort_running_task), 32'd0);
        @(negedge clk);
        finish_task_valid = 1'b0;
        cq_finish_ready   = 1'b0;
        chk("abfin_no_pulse2", 32'(abort_running_task), 32'd0);

        // Abort coincident with dispatch of the matching head
        push(4'd3, 6'd9);
        task_arvalid    = 1'b1;
        task_araddr     = 4'd3;
        abort_req_valid = 1'b1;
        abort_req_slot  = 6'd9;
        #1;
        chk("abdisp_rvalid", 32'(task_rvalid), 32'd1);
        n_disp++;
        @(negedge clk);
        task_arvalid    = 1'b0;
        abort_req_valid = 1'b0;
        n_abort++;
        chk("abdisp_pulse", 32'(abort_running_task), 32'd1);
        chk("abdisp_slot", 32'(abort_running_slot), 32'd9);
        do_start(6'd9);
        do_finish(6'd9, 3'd0, 1'b0);

        // Slot mismatch is forwarded and sticky; then reset while RUNNING
        push(4'd1, 6'd3);
        push(4'd1, 6'd4);
        do_dispatch(4'd1, 6'd3);
        chk("pre_err", 32'(slot_err), 32'd0);
        do_start(6'd4);
        chk("slot_err_set", 32'(slot_err), 32'd1);
        chk("stat_disp", stat_dispatches, exp_stat(n_disp));
        chk("stat_abort", stat_aborts, exp_stat(n_abort));
        finish_task_valid = 1'b1;
        finish_task_slot  = 6'd3;
        cq_finish_ready   = 1'b1;
        task_arvalid      = 1'b1;
        task_araddr       = 4'd1;
        #1;
        chk("pre_rst_fin_valid", 32'(cq_finish_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_fin_valid", 32'(cq_finish_valid), 32'd0);
        chk("mid_rst_fin_ready", 32'(finish_task_ready), 32'd0);
        chk("mid_rst_rvalid", 32'(task_rvalid), 32'd0);
        chk("mid_rst_tq_ready", 32'(tq_ready), 32'd1);
        chk("mid_rst_slot_err", 32'(slot_err), 32'd0);
        chk("mid_rst_abort", 32'(abort_running_task), 32'd0);
        chk("mid_rst_stat", stat_dispatches, 32'd0);
        @(negedge clk);
        finish_task_valid = 1'b0;
        cq_finish_ready   = 1'b0;
        task_arvalid      = 1'b0;
        rst               = 1'b0;
        n_disp            = 0;
        n_abort           = 0;
        @(negedge clk);
        push(4'd1, 6'd8);
        do_dispatch(4'd1, 6'd8);
        do_start(6'd8);
        do_finish(6'd8, 3'd7, 1'b1);
        chk("post_rst_stat", stat_dispatches, exp_stat(n_disp));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
